// File: rtl/add_sub.sv
// ---------------------------------------------------------------------------
// add_sub : registered WIDTH-bit unsigned adder / subtractor.
//
// The result is built by a ripple chain of WIDTH one-bit cells, bit 0 first,
// and captured in output registers on every rising clock edge (latency 1,
// one operation per cycle, no handshake).
//
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous active-high reset, clears both outputs
//   a     in   WIDTH  operand A (minuend when subtracting)
//   b     in   WIDTH  operand B (subtrahend when subtracting)
//   mode  in   1      0 = add, 1 = subtract
//   s_d   out  WIDTH  registered sum / difference
//   cout  out  1      registered carry-out (add) / borrow-out (subtract)
// ---------------------------------------------------------------------------
module add_sub #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] s_d,
  output logic             cout
);

  // Per-bit chain terms. Each cell forwards c[i+1] = gen | (c[i] & prop):
  //   add      : gen = a & b,  prop =  a ^ b
  //   subtract : gen = ~a & b, prop = ~(a ^ b)   (borrow chain, not ~carry)
  logic [WIDTH-1:0] gen_d;
  logic [WIDTH-1:0] prop_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic half_x;
      assign half_x     = a[gi] ^ b[gi];
      assign gen_d[gi]  = mode ? (~a[gi] & b[gi]) : (a[gi] & b[gi]);
      assign prop_d[gi] = mode ? ~half_x : half_x;
    end
  endgenerate

  // The ripple itself is walked in a loop with a local chain variable so the
  // carry never forms a self-referencing vector.
  always_comb begin
    logic chain;
    chain  = 1'b0;
    sum_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i] = a[i] ^ b[i] ^ chain;
      chain    = gen_d[i] | (chain & prop_d[i]);
    end
    cout_d = chain;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign s_d  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_add_sub.sv
// ---------------------------------------------------------------------------
// tb_add_sub : self-checking bench for add_sub, exercising a WIDTH=1 and a
// WIDTH=8 instance side by side against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_add_sub;

  logic       clk;
  logic       rst;
  logic       a1, b1, m1;
  logic       s1, c1;
  logic [7:0] a8, b8;
  logic       m8;
  logic [7:0] s8;
  logic       c8;

  int tests;
  int fails;

  add_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .mode(m1), .s_d(s1), .cout(c1)
  );

  add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .mode(m8), .s_d(s8), .cout(c8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic. Returns {cout, 8-bit result}.
  function automatic logic [8:0] model(input int w, input int va, input int vb,
                                       input logic sub);
    int modv;
    int r;
    logic [8:0] res;
    modv = 1 << w;
    res  = '0;
    if (!sub) begin
      r      = va + vb;
      res[7:0] = 8'(r % modv);
      res[8]   = (r >= modv);
    end else begin
      r      = va - vb + modv;
      res[7:0] = 8'(r % modv);
      res[8]   = (va < vb);
    end
    return res;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; m1 = 1'b0;
    a8 = 8'hFF; b8 = 8'h01; m8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (s1 !== 1'b0 || c1 !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold_w1 cyc%0d: got s=%b c=%b, want s=0 c=0", i, s1, c1);
      end
      tests++;
      if (s8 !== 8'h00 || c8 !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold_w8 cyc%0d: got s=%h c=%b, want s=00 c=0", i, s8, c8);
      end
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (s1 !== 1'b0 || c1 !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_w1: got s=%b c=%b, want s=0 c=1", s1, c1);
    end
    tests++;
    if (s8 !== 8'h00 || c8 !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_w8: got s=%h c=%b, want s=00 c=1", s8, c8);
    end
    $display("[TB] reset: hold and release checked");
  endtask

  // WIDTH=1 truth-table sweeps, expectations taken straight from the table.
  task automatic test_add_sweep;
    logic [1:0] ab_tab  [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    logic [1:0] exp_tab [4] = '{2'b01, 2'b10, 2'b10, 2'b00}; // {s, c}
    m1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1 = ab_tab[i][1]; b1 = ab_tab[i][0];
      @(posedge clk); #1;
      tests++;
      if ({s1, c1} !== exp_tab[i]) begin
        fails++;
        $display("FAIL add_sweep a=%b b=%b: got s=%b c=%b, want s=%b c=%b",
                 a1, b1, s1, c1, exp_tab[i][1], exp_tab[i][0]);
      end else
        $display("[TB] add_sweep a=%b b=%b -> s=%b c=%b", a1, b1, s1, c1);
    end
  endtask

  task automatic test_sub_sweep;
    logic [1:0] ab_tab  [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [1:0] exp_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b00};
    m1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = ab_tab[i][1]; b1 = ab_tab[i][0];
      @(posedge clk); #1;
      tests++;
      if ({s1, c1} !== exp_tab[i]) begin
        fails++;
        $display("FAIL sub_sweep a=%b b=%b: got s=%b c=%b, want s=%b c=%b",
                 a1, b1, s1, c1, exp_tab[i][1], exp_tab[i][0]);
      end else
        $display("[TB] sub_sweep a=%b b=%b -> s=%b c=%b", a1, b1, s1, c1);
    end
  endtask

  // Changing operands between edges must not reach the outputs early.
  task automatic test_latency_glitch;
    a8 = 8'h03; b8 = 8'h04; m8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'hC8;
    #3;
    tests++;
    if (s8 !== 8'h07 || c8 !== 1'b0) begin
      fails++;
      $display("FAIL glitch_hold: got s=%h c=%b, want s=07 c=0", s8, c8);
    end
    @(posedge clk); #1;
    tests++;
    if (s8 !== 8'hCC || c8 !== 1'b0) begin
      fails++;
      $display("FAIL glitch_next_edge: got s=%h c=%b, want s=cc c=0", s8, c8);
    end
    $display("[TB] latency: mid-cycle change held until next edge");
  endtask

  task automatic test_w8_boundaries;
    logic [7:0] ta [5] = '{8'hFF, 8'h05, 8'h80, 8'hFF, 8'h00};
    logic [7:0] tb [5] = '{8'h01, 8'h07, 8'h80, 8'hFF, 8'h01};
    logic       tm [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [8:0] te [5] = '{9'h100, 9'h1FE, 9'h000, 9'h1FE, 9'h1FF};
    for (int i = 0; i < 5; i++) begin
      a8 = ta[i]; b8 = tb[i]; m8 = tm[i];
      @(posedge clk); #1;
      tests++;
      if ({c8, s8} !== te[i]) begin
        fails++;
        $display("FAIL w8_boundary a=%h b=%h mode=%b: got s=%h c=%b, want s=%h c=%b",
                 ta[i], tb[i], tm[i], s8, c8, te[i][7:0], te[i][8]);
      end else
        $display("[TB] w8_boundary a=%h b=%h mode=%b -> s=%h c=%b", ta[i], tb[i], tm[i], s8, c8);
    end
  endtask

  // New random operands and mode every cycle on both instances.
  task automatic test_back_to_back;
    logic [8:0] e8, e1;
    for (int i = 0; i < 60; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); m1 = 1'($urandom);
      e8 = model(8, int'(a8), int'(b8), m8);
      e1 = model(1, int'(a1), int'(b1), m1);
      @(posedge clk); #1;
      tests++;
      if ({c8, s8} !== e8) begin
        fails++;
        $display("FAIL rand_w8 a=%h b=%h mode=%b: got s=%h c=%b, want s=%h c=%b",
                 a8, b8, m8, s8, c8, e8[7:0], e8[8]);
      end else
        $display("[TB] rand_w8 a=%h b=%h mode=%b -> s=%h c=%b", a8, b8, m8, s8, c8);
      tests++;
      if (s1 !== e1[0] || c1 !== e1[8]) begin
        fails++;
        $display("FAIL rand_w1 a=%b b=%b mode=%b: got s=%b c=%b, want s=%b c=%b",
                 a1, b1, m1, s1, c1, e1[0], e1[8]);
      end
    end
  endtask

  // Reset pulse between edges while operations stream through.
  task automatic test_async_reset_midstream;
    logic [8:0] e8;
    for (int k = 0; k < 4; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
      e8 = model(8, int'(a8), int'(b8), m8);
      @(posedge clk); #1;
      tests++;
      if ({c8, s8} !== e8) begin
        fails++;
        $display("FAIL stream_pre a=%h b=%h mode=%b: got s=%h c=%b, want s=%h c=%b",
                 a8, b8, m8, s8, c8, e8[7:0], e8[8]);
      end
      // Force non-zero expectations where possible so the drop is visible.
      a8 = 8'hFF; b8 = 8'hFF; m8 = 1'b0;
      #1 rst = 1'b1;
      #1;
      tests++;
      if (s8 !== 8'h00 || c8 !== 1'b0) begin
        fails++;
        $display("FAIL async_drop k=%0d: got s=%h c=%b, want s=00 c=0", k, s8, c8);
      end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (s8 !== 8'hFE || c8 !== 1'b1) begin
        fails++;
        $display("FAIL async_resume k=%0d: got s=%h c=%b, want s=fe c=1", k, s8, c8);
      end else
        $display("[TB] async_reset k=%0d: dropped to 0, resumed s=%h c=%b", k, s8, c8);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; m1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; m8 = 1'b0;
    #1;
    test_reset();
    test_add_sweep();
    test_sub_sweep();
    test_latency_glitch();
    test_w8_boundaries();
    test_back_to_back();
    test_async_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
